imem_port_arbiter: RTL and testbench
====================================

# imem_port_arbiter

Two-requester arbiter and access sequencer for the shared single-port instruction/data memory of the multi-cycle CPU. It accepts word requests from the instruction-fetch stage (IF) and the load/store stage (DM), grants the memory port round-robin, and holds each access for a fixed number of memory cycles. It returns registered read data and a one-cycle completion pulse, and flags misaligned addresses without touching memory.

## Interface
Parameters:
- LAT, 2, memory access cycles per transfer (≥1)
- AW, 32, address width
- DW, 32, data width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- if_req  in  1  IF request, held until if_gnt
- if_addr  in  AW  IF byte address (read only)
- if_gnt  out  1  one-cycle grant pulse to IF
- if_valid  out  1  one-cycle completion pulse to IF
- if_err  out  1  with if_valid: misaligned address
- if_rdata  out  DW  IF read data, held until next if_valid
- dm_req  in  1  DM request, held until dm_gnt
- dm_we  in  1  DM write enable
- dm_addr  in  AW  DM byte address
- dm_wdata  in  DW  DM write data
- dm_gnt, dm_valid, dm_err, dm_rdata  out  1/1/1/DW  same meaning as the IF ports
- mem_en  out  1  memory access active
- mem_we  out  1  memory write strobe
- mem_addr  out  AW  latched byte address
- mem_wdata  out  DW  latched write data
- mem_rdata  in  DW  memory read data, valid in the last ACCESS cycle
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, ACCESS, RESP.
- Arbitration takes place at a rising edge in IDLE or RESP when any req is high.
  - Only one req high: that requester wins.
  - Both high: the requester that is not `last` wins.
  - On a win: `last` updates, addr/we/wdata are latched, and the winner's gnt is registered high for exactly one cycle.
- Aligned win: go to ACCESS with cnt=LAT-1.
  - mem_en=1 for the whole ACCESS state.
  - mem_we=dm_we latched; IF accesses are always reads.
  - mem_addr and mem_wdata come from the latch and stay stable.
  - cnt decrements each cycle. At the edge ending the cnt==0 cycle, mem_rdata is captured into the owner's rdata register (reads only), and the state moves to RESP with the owner's valid=1.
- Misaligned win (addr[1:0]≠0): go straight to RESP with valid=1 and err=1. No mem_en, and rdata is unchanged.
- RESP lasts one cycle and arbitrates exactly as IDLE does (back-to-back grant allowed). With no req it returns to IDLE.
- A write completion pulses dm_valid, and dm_rdata is unchanged.
- No req is sampled while in ACCESS.
- Reset (rst=0, any time, including mid-ACCESS):
  - State goes to IDLE.
  - `last`=DM, so IF wins the first tie.
  - cnt=0; all gnt/valid/err/mem_en/mem_we/busy=0; mem_addr, mem_wdata, if_rdata, dm_rdata=0.
  - An aborted access produces no valid pulse.

## Timing
- Edge E0 samples req: gnt is high in cycle E0–E1, and mem_en is high for cycles E0…E0+LAT.
- valid is high in cycle E0+LAT … E0+LAT+1: request-to-completion latency is LAT+1 edges.
- Misaligned request: valid/err high in cycle E0–E1, coincident with gnt.
- Sustained throughput with both requesters active: one transfer per LAT+1 cycles, strictly alternating IF/DM.
- All outputs are registered. No combinational path from any req to any output.

## Test plan
- Reset, then if_req=1, if_addr=0x00003000, mem returns 0x2010000A (LAT=2):
  - if_gnt in cycle 1.
  - mem_en in cycles 1–2.
  - if_valid in cycle 3 with if_rdata=0x2010000A.
  - busy low after RESP.
- if_req and dm_req both high from the first edge after reset:
  - IF is granted first, then DM, then IF.
  - Grants are LAT+1 cycles apart, and `last` alternates.
- dm_we=1, dm_addr=0x00003010, dm_wdata=0xDEADBEEF:
  - mem_we=1 and mem_addr/mem_wdata stable for LAT cycles.
  - dm_valid pulses once; dm_rdata unchanged.
- dm_addr=0x00003002: dm_gnt, dm_valid and dm_err all in the same cycle; mem_en stays 0.
- Pull rst low in the middle of the ACCESS cycle of an IF read:
  - All outputs go to 0 immediately.
  - No if_valid appears.
  - The first post-reset tie is granted to IF.
- LAT=1 build, IF held continuously with the address incrementing by 4: valid every 2 cycles, with the correct data per address.

Source files
------------

// File: rtl/imem_port_arbiter.sv
// Round-robin arbiter and access sequencer for the shared single-port
// instruction/data memory; serves IF and DM word requests with fixed latency.
module imem_port_arbiter #(
  parameter int unsigned LAT = 2,
  parameter int unsigned AW  = 32,
  parameter int unsigned DW  = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_valid,
  output logic          if_err,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_valid,
  output logic          dm_err,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int unsigned CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          last, last_d;   // 1: DM owns/owned the port most recently
  logic          we_q, we_d;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] wdata_d;
  logic          if_gnt_d, dm_gnt_d, if_valid_d, dm_valid_d, if_err_d, dm_err_d;
  logic          mem_en_d, mem_we_d, busy_d;
  logic [DW-1:0] if_rdata_d, dm_rdata_d;
  logic          pick;
  logic [AW-1:0] sel_addr;

  // Next-state, arbitration and registered-output computation
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    last_d     = last;
    we_d       = we_q;
    addr_d     = mem_addr;
    wdata_d    = mem_wdata;
    if_gnt_d   = 1'b0;
    dm_gnt_d   = 1'b0;
    if_valid_d = 1'b0;
    dm_valid_d = 1'b0;
    if_err_d   = 1'b0;
    dm_err_d   = 1'b0;
    mem_en_d   = 1'b0;
    mem_we_d   = 1'b0;
    if_rdata_d = if_rdata;
    dm_rdata_d = dm_rdata;
    pick       = 1'b0;
    sel_addr   = if_addr;

    case (state)
      ACCESS: begin
        if (cnt == '0) begin
          state_d    = RESP;
          if_valid_d = ~last;
          dm_valid_d = last;
          if (!we_q) begin
            if (last) dm_rdata_d = mem_rdata;
            else      if_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d    = cnt - CW'(1);
          mem_en_d = 1'b1;
          mem_we_d = we_q;
        end
      end
      default: begin
        // IDLE and RESP both arbitrate; a tie goes to whoever was not last
        state_d = IDLE;
        if (if_req || dm_req) begin
          pick     = dm_req & (~if_req | ~last);
          sel_addr = pick ? dm_addr : if_addr;
          last_d   = pick;
          addr_d   = sel_addr;
          we_d     = pick & dm_we;
          if (pick) wdata_d = dm_wdata;
          if_gnt_d = ~pick;
          dm_gnt_d = pick;
          if (sel_addr[1:0] != 2'b00) begin
            state_d    = RESP;
            if_valid_d = ~pick;
            dm_valid_d = pick;
            if_err_d   = ~pick;
            dm_err_d   = pick;
          end else begin
            state_d  = ACCESS;
            cnt_d    = CW'(LAT - 1);
            mem_en_d = 1'b1;
            mem_we_d = pick & dm_we;
          end
        end
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      last      <= 1'b1;
      we_q      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_gnt    <= 1'b0;
      dm_gnt    <= 1'b0;
      if_valid  <= 1'b0;
      dm_valid  <= 1'b0;
      if_err    <= 1'b0;
      dm_err    <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      busy      <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      last      <= last_d;
      we_q      <= we_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      if_gnt    <= if_gnt_d;
      dm_gnt    <= dm_gnt_d;
      if_valid  <= if_valid_d;
      dm_valid  <= dm_valid_d;
      if_err    <= if_err_d;
      dm_err    <= dm_err_d;
      mem_en    <= mem_en_d;
      mem_we    <= mem_we_d;
      busy      <= busy_d;
      if_rdata  <= if_rdata_d;
      dm_rdata  <= dm_rdata_d;
    end
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: directed scenarios plus a randomized run
// checked against a transaction-schedule model of the arbiter.
module tb_imem_port_arbiter;

  localparam int unsigned LAT = 2;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int          NC  = 300;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          if_req, if_gnt, if_valid, if_err;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          dm_req, dm_we, dm_gnt, dm_valid, dm_err;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata, dm_rdata;
  logic          mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic          u_if_req, u_if_gnt, u_if_valid, u_if_err;
  logic [AW-1:0] u_if_addr;
  logic [DW-1:0] u_if_rdata;
  logic          u_dm_req, u_dm_we, u_dm_gnt, u_dm_valid, u_dm_err;
  logic [AW-1:0] u_dm_addr;
  logic [DW-1:0] u_dm_wdata, u_dm_rdata;
  logic          u_mem_en, u_mem_we, u_busy;
  logic [AW-1:0] u_mem_addr;
  logic [DW-1:0] u_mem_wdata, u_mem_rdata;

  int checks   = 0;
  int failures = 0;

  imem_port_arbiter #(.LAT(LAT), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid),
    .if_err(if_err), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_valid(dm_valid), .dm_err(dm_err), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  imem_port_arbiter #(.LAT(1), .AW(AW), .DW(DW)) dut1 (
    .clk(clk), .rst(rst),
    .if_req(u_if_req), .if_addr(u_if_addr), .if_gnt(u_if_gnt), .if_valid(u_if_valid),
    .if_err(u_if_err), .if_rdata(u_if_rdata),
    .dm_req(u_dm_req), .dm_we(u_dm_we), .dm_addr(u_dm_addr), .dm_wdata(u_dm_wdata),
    .dm_gnt(u_dm_gnt), .dm_valid(u_dm_valid), .dm_err(u_dm_err), .dm_rdata(u_dm_rdata),
    .mem_en(u_mem_en), .mem_we(u_mem_we), .mem_addr(u_mem_addr), .mem_wdata(u_mem_wdata),
    .mem_rdata(u_mem_rdata), .busy(u_busy)
  );

  // Memory environment: unwritten words read back a fixed address pattern
  logic [31:0] pmem [int unsigned];
  logic [31:0] rmem [int unsigned];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] pmem_rd(input logic [31:0] a);
    if (pmem.exists(32'(a >> 2))) return pmem[32'(a >> 2)];
    return init_word(a);
  endfunction

  always @(posedge clk) if (mem_en && mem_we) pmem[32'(mem_addr >> 2)] = mem_wdata;
  always @(negedge clk) mem_rdata = pmem_rd(mem_addr);
  assign u_mem_rdata = u_mem_addr ^ 32'h1111_0000;

  function automatic logic [8:0] flags();
    return {if_gnt, dm_gnt, if_valid, dm_valid, if_err, dm_err, mem_en, mem_we, busy};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    u_if_req = 1'b0; u_if_addr = '0;
    u_dm_req = 1'b0; u_dm_we = 1'b0; u_dm_addr = '0; u_dm_wdata = '0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [8:0] f;
    do_reset();
    f = flags();
    checks++;
    if (f !== 9'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=%b", f, 9'b0);
    end
    checks++;
    if ({mem_addr, mem_wdata, if_rdata, dm_rdata} !== '0) begin
      failures++;
      $display("FAIL reset_data got=%h/%h/%h/%h exp=0", mem_addr, mem_wdata, if_rdata, dm_rdata);
    end
    checks++;
    if ({u_if_gnt, u_if_valid, u_if_err, u_dm_gnt, u_dm_valid, u_dm_err, u_mem_en, u_mem_we, u_busy} !== 9'b0 ||
        {u_if_rdata, u_dm_rdata, u_mem_addr, u_mem_wdata} !== '0) begin
      failures++;
      $display("FAIL reset_lat1 got flags=%b%b%b%b%b%b%b%b%b exp=0", u_if_gnt, u_if_valid, u_if_err,
               u_dm_gnt, u_dm_valid, u_dm_err, u_mem_en, u_mem_we, u_busy);
    end
  endtask

  task automatic test_if_read();
    logic [8:0] e, f;
    do_reset();
    pmem.delete();
    pmem[32'h3000 >> 2] = 32'h2010_000A;
    if_req = 1'b1;
    if_addr = 32'h0000_3000;
    for (int c = 0; c <= int'(LAT) + 1; c++) begin
      tick();
      e = {c == 0, 1'b0, c == int'(LAT), 1'b0, 1'b0, 1'b0, c < int'(LAT), 1'b0, c <= int'(LAT)};
      f = flags();
      checks++;
      if (f !== e) begin
        failures++;
        $display("FAIL if_read_flags cyc=%0d got=%b exp=%b", c, f, e);
      end
      if (c == int'(LAT)) begin
        checks++;
        if (if_rdata !== 32'h2010_000A) begin
          failures++;
          $display("FAIL if_read_data got=%h exp=%h", if_rdata, 32'h2010_000A);
        end
      end
      if (c == 0) if_req = 1'b0;
    end
  endtask

  task automatic test_arb_tie();
    logic [8:0] e, f;
    int p, k, idx;
    bit wdm;
    do_reset();
    pmem.delete();
    if_req = 1'b1; if_addr = 32'h3100;
    dm_req = 1'b1; dm_addr = 32'h3200; dm_we = 1'b0;
    p = int'(LAT) + 1;
    for (int c = 0; c < 3 * p; c++) begin
      tick();
      k = c % p;
      idx = c / p;
      wdm = (idx % 2) == 1;
      e = {k == 0 && !wdm, k == 0 && wdm, k == int'(LAT) && !wdm, k == int'(LAT) && wdm,
           1'b0, 1'b0, k < int'(LAT), 1'b0, 1'b1};
      f = flags();
      checks++;
      if (f !== e) begin
        failures++;
        $display("FAIL tie_flags cyc=%0d got=%b exp=%b", c, f, e);
      end
      if (k == int'(LAT) && wdm) begin
        checks++;
        if (dm_rdata !== init_word(32'h3200)) begin
          failures++;
          $display("FAIL tie_dm_data got=%h exp=%h", dm_rdata, init_word(32'h3200));
        end
      end
    end
    if_req = 1'b0;
    dm_req = 1'b0;
  endtask

  task automatic test_write();
    logic [8:0] e, f;
    do_reset();
    pmem.delete();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h0000_3010; dm_wdata = 32'hDEAD_BEEF;
    for (int c = 0; c <= int'(LAT) + 1; c++) begin
      tick();
      e = {1'b0, c == 0, 1'b0, c == int'(LAT), 1'b0, 1'b0, c < int'(LAT), c < int'(LAT), c <= int'(LAT)};
      f = flags();
      checks++;
      if (f !== e) begin
        failures++;
        $display("FAIL write_flags cyc=%0d got=%b exp=%b", c, f, e);
      end
      if (c < int'(LAT)) begin
        checks++;
        if (mem_addr !== 32'h3010 || mem_wdata !== 32'hDEAD_BEEF) begin
          failures++;
          $display("FAIL write_bus cyc=%0d got=%h/%h exp=%h/%h", c, mem_addr, mem_wdata, 32'h3010, 32'hDEAD_BEEF);
        end
      end
      if (c == int'(LAT)) begin
        checks++;
        if (dm_rdata !== 32'h0) begin
          failures++;
          $display("FAIL write_rdata_held got=%h exp=%h", dm_rdata, 32'h0);
        end
      end
      if (c == 0) begin
        dm_req = 1'b0;
        dm_we = 1'b0;
      end
    end
    checks++;
    if (pmem_rd(32'h3010) !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL write_mem got=%h exp=%h", pmem_rd(32'h3010), 32'hDEAD_BEEF);
    end
  endtask

  task automatic test_misaligned();
    logic [8:0] e, f;
    do_reset();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_3002;
    for (int c = 0; c < 3; c++) begin
      tick();
      e = (c == 0) ? 9'b010101001 : 9'b0;
      f = flags();
      checks++;
      if (f !== e) begin
        failures++;
        $display("FAIL misaligned_flags cyc=%0d got=%b exp=%b", c, f, e);
      end
      if (c == 0) begin
        checks++;
        if (dm_rdata !== 32'h0) begin
          failures++;
          $display("FAIL misaligned_rdata got=%h exp=%h", dm_rdata, 32'h0);
        end
        dm_req = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [8:0] e, f;
    do_reset();
    if_req = 1'b1; if_addr = 32'h3000;
    tick();
    if_req = 1'b0;
    #2 rst = 1'b0;
    #1;
    f = flags();
    checks++;
    if (f !== 9'b0 || mem_addr !== '0 || if_rdata !== '0) begin
      failures++;
      $display("FAIL reset_mid_async got=%b addr=%h rdata=%h exp=0", f, mem_addr, if_rdata);
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      f = flags();
      checks++;
      if (f !== 9'b0) begin
        failures++;
        $display("FAIL reset_mid_hold cyc=%0d got=%b exp=%b", c, f, 9'b0);
      end
    end
    if_req = 1'b1; if_addr = 32'h3000;
    dm_req = 1'b1; dm_addr = 32'h3200; dm_we = 1'b0;
    rst = 1'b1;
    for (int c = 0; c <= int'(LAT); c++) begin
      tick();
      e = {c == 0, 1'b0, c == int'(LAT), 1'b0, 1'b0, 1'b0, c < int'(LAT), 1'b0, 1'b1};
      f = flags();
      checks++;
      if (f !== e) begin
        failures++;
        $display("FAIL reset_mid_after cyc=%0d got=%b exp=%b", c, f, e);
      end
      if (c == 0) if_req = 1'b0;
    end
    dm_req = 1'b0;
  endtask

  // Schedule model: each win books its gnt, mem_en window and completion cycle
  task automatic test_random();
    logic [8:0]  expf [512];
    bit          upd_if [512];
    bit          upd_dm [512];
    logic [31:0] dat_if [512];
    logic [31:0] dat_dm [512];
    logic [31:0] exp_if_rd, exp_dm_rd, a, d;
    logic [8:0]  f;
    int          free_edge;
    bit          last_dm, pick_dm, w, g_if, g_dm;
    do_reset();
    pmem.delete();
    rmem.delete();
    for (int i = 0; i < 512; i++) begin
      expf[i] = '0; upd_if[i] = 0; upd_dm[i] = 0; dat_if[i] = '0; dat_dm[i] = '0;
    end
    free_edge = 0;
    last_dm = 1'b1;
    exp_if_rd = '0;
    exp_dm_rd = '0;
    for (int c = 0; c < NC; c++) begin
      g_if = 1'b0;
      g_dm = 1'b0;
      if (c >= free_edge && (if_req || dm_req)) begin
        pick_dm = dm_req && (!if_req || !last_dm);
        last_dm = pick_dm;
        a = pick_dm ? dm_addr : if_addr;
        w = pick_dm && dm_we;
        g_if = !pick_dm;
        g_dm = pick_dm;
        expf[c][8] = g_if;
        expf[c][7] = g_dm;
        if (a[1:0] != 2'b00) begin
          expf[c][6] = g_if; expf[c][5] = g_dm;
          expf[c][4] = g_if; expf[c][3] = g_dm;
          expf[c][0] = 1'b1;
          free_edge = c + 1;
        end else begin
          for (int k = 0; k < int'(LAT); k++) begin
            expf[c + k][2] = 1'b1;
            expf[c + k][1] = w;
          end
          for (int k = 0; k <= int'(LAT); k++) expf[c + k][0] = 1'b1;
          expf[c + int'(LAT)][6] = g_if;
          expf[c + int'(LAT)][5] = g_dm;
          if (w) rmem[32'(a >> 2)] = dm_wdata;
          else begin
            d = rmem.exists(32'(a >> 2)) ? rmem[32'(a >> 2)] : init_word(a);
            if (pick_dm) begin upd_dm[c + int'(LAT)] = 1; dat_dm[c + int'(LAT)] = d; end
            else begin upd_if[c + int'(LAT)] = 1; dat_if[c + int'(LAT)] = d; end
          end
          free_edge = c + int'(LAT) + 1;
        end
      end
      tick();
      f = flags();
      checks++;
      if (f !== expf[c]) begin
        failures++;
        $display("FAIL rand_flags cyc=%0d got=%b exp=%b", c, f, expf[c]);
      end
      if (upd_if[c]) exp_if_rd = dat_if[c];
      if (upd_dm[c]) exp_dm_rd = dat_dm[c];
      checks++;
      if (if_rdata !== exp_if_rd || dm_rdata !== exp_dm_rd) begin
        failures++;
        $display("FAIL rand_rdata cyc=%0d got=%h/%h exp=%h/%h", c, if_rdata, dm_rdata, exp_if_rd, exp_dm_rd);
      end
      if (g_if) if_req = 1'b0;
      else if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1'b1;
        if_addr = 32'h3000 + 32'($urandom_range(0, 15) << 2) +
                  (($urandom_range(0, 5) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
      end
      if (g_dm) dm_req = 1'b0;
      else if (!dm_req && $urandom_range(0, 2) == 0) begin
        dm_req = 1'b1;
        dm_we = 1'($urandom_range(0, 1));
        dm_wdata = $urandom;
        dm_addr = 32'h3000 + 32'($urandom_range(0, 15) << 2) +
                  (($urandom_range(0, 5) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
      end
    end
    if_req = 1'b0;
    dm_req = 1'b0;
  endtask

  task automatic test_lat1_stream();
    logic [2:0]  e, f;
    logic [31:0] exp_d;
    do_reset();
    u_if_req = 1'b1;
    u_if_addr = 32'h4000;
    for (int c = 0; c < 16; c++) begin
      tick();
      e = {c % 2 == 0, c % 2 == 1, c % 2 == 0};
      f = {u_if_gnt, u_if_valid, u_mem_en};
      checks++;
      if (f !== e) begin
        failures++;
        $display("FAIL lat1_flags cyc=%0d got=%b exp=%b", c, f, e);
      end
      if (c % 2 == 1) begin
        exp_d = (32'h4000 + 32'(4 * (c / 2))) ^ 32'h1111_0000;
        checks++;
        if (u_if_rdata !== exp_d) begin
          failures++;
          $display("FAIL lat1_data cyc=%0d got=%h exp=%h", c, u_if_rdata, exp_d);
        end
      end
      if (c % 2 == 0) u_if_addr = u_if_addr + 32'd4;
    end
    u_if_req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_if_read();
    test_arb_tie();
    test_write();
    test_misaligned();
    test_reset_mid();
    test_random();
    test_lat1_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
